// File: rtl/sevenseg_frame_decoder.sv
// sevenseg_frame_decoder
//   Samples a multiplexed seven-segment bus (seg + an), waits for each digit
//   pattern to dwell for STABLE_CYCLES identical samples, decodes it back to a
//   hex nibble and assembles DIGITS nibbles into one frame. Completed frames
//   leave on a valid/ready output; a frame that completes while the output is
//   still occupied is dropped and flagged with a one-cycle overrun pulse.
//   Build option: define SEVENSEG_ACTIVE_LOW_EN for common-anode boards
//   (seg and an active-low); by default both are active-high.
module sevenseg_frame_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_err,
  output logic [DIGITS-1:0]     frame_dp,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  // Counter saturates at CNT_MAX; the capture fires on the step into it.
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

  // Polarity normalisation ahead of the input register.
  logic [7:0]        seg_in;
  logic [DIGITS-1:0] an_in;

`ifdef SEVENSEG_ACTIVE_LOW_EN
  assign seg_in = ~seg;
  assign an_in  = ~an;
`else
  assign seg_in = seg;
  assign an_in  = an;
`endif

  // Input stage and previous-sample copy.
  logic [7:0]        s_seg_q, p_seg_q;
  logic [DIGITS-1:0] s_an_q,  p_an_q;

  // Stability counter and capture strobe.
  logic [7:0] cnt_q, cnt_d;
  logic       capture;

  // Slot storage for the frame being collected.
  logic [4*DIGITS-1:0] slot_nib_q, slot_nib_d;
  logic [DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [DIGITS-1:0]   slot_dp_q,  slot_dp_d;
  logic [DIGITS-1:0]   fill_q,     fill_d;

  // Frame output registers.
  logic [4*DIGITS-1:0] frame_data_q,  frame_data_d;
  logic [DIGITS-1:0]   frame_err_q,   frame_err_d;
  logic [DIGITS-1:0]   frame_dp_q,    frame_dp_d;
  logic                frame_valid_q, frame_valid_d;
  logic                overrun_q,     overrun_d;

  // Decoded view of the current sample.
  logic [3:0] dec_nib;
  logic       dec_err;
  logic       frame_full, out_free, load, drop;

  // Map a 7-bit segment code (a..g) to {err, nibble}; unknown codes give err=1, nibble=0.
  function automatic logic [4:0] decode7(input logic [6:0] code);
    logic [4:0] r;
    case (code)
      7'h3f: r = {1'b0, 4'h0};
      7'h06: r = {1'b0, 4'h1};
      7'h5b: r = {1'b0, 4'h2};
      7'h4f: r = {1'b0, 4'h3};
      7'h66: r = {1'b0, 4'h4};
      7'h6d: r = {1'b0, 4'h5};
      7'h7d: r = {1'b0, 4'h6};
      7'h07: r = {1'b0, 4'h7};
      7'h7f: r = {1'b0, 4'h8};
      7'h6f: r = {1'b0, 4'h9};
      7'h77: r = {1'b0, 4'ha};
      7'h7c: r = {1'b0, 4'hb};
      7'h39: r = {1'b0, 4'hc};
      7'h5e: r = {1'b0, 4'hd};
      7'h79: r = {1'b0, 4'he};
      7'h71: r = {1'b0, 4'hf};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  assign {dec_err, dec_nib} = decode7(s_seg_q[6:0]);

  // Register the bus and keep the previous sample for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q <= '0;
      s_an_q  <= '0;
      p_seg_q <= '0;
      p_an_q  <= '0;
    end else begin
      // NOTE: non-blocking so p_* takes the old s_* value, forming a real pipeline.
      s_seg_q <= seg_in;
      s_an_q  <= an_in;
      p_seg_q <= s_seg_q;
      p_an_q  <= s_an_q;
    end
  end

  // Count identical one-hot samples; saturate so one dwell yields one capture.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cnt_d   = '0;
    capture = 1'b0;
    if ((s_seg_q == p_seg_q) && (s_an_q == p_an_q) && $onehot(s_an_q)) begin
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      capture = (cnt_q == CNT_PRE);
    end
  end

  // Frame completion and output availability.
  assign frame_full = &fill_q;
  assign out_free   = !frame_valid_q || frame_ready;
  assign load       = frame_full && out_free;
  assign drop       = frame_full && !out_free;

  // Slot writes on capture; a full frame (loaded or dropped) clears the fill mask.
  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
    slot_dp_d  = slot_dp_q;
    fill_d     = frame_full ? '0 : fill_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && s_an_q[i]) begin
        slot_nib_d[4*i +: 4] = dec_nib;
        slot_err_d[i]        = dec_err;
        slot_dp_d[i]         = s_seg_q[7];
        fill_d[i]            = 1'b1;
      end
    end
  end

  // Output side: handshake drops valid, a load (same edge allowed) re-asserts it.
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_err_d   = frame_err_q;
    frame_dp_d    = frame_dp_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = drop;
    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    if (load) begin
      frame_data_d  = slot_nib_q;
      frame_err_d   = slot_err_q;
      frame_dp_d    = slot_dp_q;
      frame_valid_d = 1'b1;
    end
  end

  // State registers for counter, slots and frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      fill_q        <= '0;
      // NOTE: slot contents are reset too; they are a few flops, not a RAM, and
      // clearing them keeps a post-reset frame free of stale data.
      slot_nib_q    <= '0;
      slot_err_q    <= '0;
      slot_dp_q     <= '0;
      frame_data_q  <= '0;
      frame_err_q   <= '0;
      frame_dp_q    <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      slot_nib_q    <= slot_nib_d;
      slot_err_q    <= slot_err_d;
      slot_dp_q     <= slot_dp_d;
      frame_data_q  <= frame_data_d;
      frame_err_q   <= frame_err_d;
      frame_dp_q    <= frame_dp_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_err   = frame_err_q;
  assign frame_dp    = frame_dp_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule
